// File: rtl/crc_pkg.sv
// Shared types and standard polynomial sets for the serial CRC engine.
package crc_pkg;

    typedef enum logic {
        ST_ACC    = 1'b0,
        ST_APPEND = 1'b1
    } crc_state_t;

    // USB token CRC5
    localparam logic [4:0]  USB5_POLY      = 5'h05;
    localparam logic [4:0]  USB5_INIT      = 5'h1F;
    localparam logic [4:0]  USB5_RESIDUAL  = 5'h0C;

    // USB data packet CRC16
    localparam logic [15:0] USB16_POLY     = 16'h8005;
    localparam logic [15:0] USB16_INIT     = 16'hFFFF;
    localparam logic [15:0] USB16_RESIDUAL = 16'h800D;

    // SD command CRC7
    localparam logic [6:0]  SD7_POLY       = 7'h09;
    localparam logic [6:0]  SD7_INIT       = 7'h00;
    localparam logic [6:0]  SD7_RESIDUAL   = 7'h00;

    // SD data line CRC16-CCITT
    localparam logic [15:0] SD16_POLY      = 16'h1021;
    localparam logic [15:0] SD16_INIT      = 16'h0000;
    localparam logic [15:0] SD16_RESIDUAL  = 16'h0000;

endpackage

// File: rtl/crc_lfsr.sv
// CRC register with MSB-first serial update; load_init takes priority over shift.
module crc_lfsr #(
    parameter int              CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY = 16'h8005,
    parameter logic [CRC_W-1:0] INIT = '1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_init,
    input  logic             shift_en,
    input  logic             data_in,
    output logic [CRC_W-1:0] crc
);

    logic             fb;
    logic [CRC_W-1:0] crc_next;

    // Next register value for one incoming bit: shift left, fold in POLY on feedback.
    always_comb begin
        fb       = data_in ^ crc[CRC_W-1];
        crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    // CRC register: reset and clear both reload INIT.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc <= INIT;
        end else if (load_init) begin
            crc <= INIT;
        end else if (shift_en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/crc_gen_chk.sv
// Serial CRC generator/checker: accumulates a bit stream, serialises the CRC, checks residual.
module crc_gen_chk
    import crc_pkg::*;
#(
    parameter int               CRC_W    = 16,
    parameter logic [CRC_W-1:0] POLY     = USB16_POLY,
    parameter logic [CRC_W-1:0] INIT     = '1,
    parameter bit               OUT_INV  = 1'b1,
    parameter logic [CRC_W-1:0] RESIDUAL = USB16_RESIDUAL,
    parameter int               CNT_W    = 12
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             shift_enable,
    input  logic             serial_in,
    input  logic             append_start,
    input  logic             append_advance,
    output logic             crc_out_bit,
    output logic             append_active,
    output logic             append_done,
    output logic [CRC_W-1:0] crc_value,
    output logic             crc_ok,
    output logic [CNT_W-1:0] bit_count,
    output logic             err
);

    localparam int AW = $clog2(CRC_W + 1);

    crc_state_t       state, state_next;
    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] tx_sr;
    logic [AW-1:0]    append_cnt;
    logic             shift_ok;
    logic             load_tx;
    logic             adv_tx;
    logic             done_next;
    logic             err_set;

    crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .clk       (clk),
        .n_rst     (n_rst),
        .load_init (clear),
        .shift_en  (shift_ok),
        .data_in   (serial_in),
        .crc       (crc)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle controls; clear beats append_start beats shift_enable.
    always_comb begin
        state_next = state;
        shift_ok   = 1'b0;
        load_tx    = 1'b0;
        adv_tx     = 1'b0;
        done_next  = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_ACC: begin
                if (clear) begin
                    state_next = ST_ACC;
                end else if (append_start) begin
                    load_tx    = 1'b1;
                    state_next = ST_APPEND;
                    err_set    = shift_enable;
                end else if (shift_enable) begin
                    shift_ok = 1'b1;
                end
            end
            ST_APPEND: begin
                if (clear) begin
                    state_next = ST_ACC;
                end else begin
                    err_set = shift_enable | append_start;
                    if (append_advance) begin
                        adv_tx = 1'b1;
                        if (append_cnt == AW'(1)) begin
                            state_next = ST_ACC;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    // Transmit shift register, append counter, done pulse, sticky error and bit counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_sr       <= '0;
            append_cnt  <= '0;
            append_done <= 1'b0;
            err         <= 1'b0;
            bit_count   <= '0;
        end else begin
            append_done <= done_next;
            if (clear) begin
                tx_sr      <= '0;
                append_cnt <= '0;
                err        <= 1'b0;
                bit_count  <= '0;
            end else begin
                if (load_tx) begin
                    tx_sr      <= OUT_INV ? ~crc : crc;
                    append_cnt <= AW'(CRC_W);
                end else if (adv_tx) begin
                    tx_sr      <= {tx_sr[CRC_W-2:0], 1'b0};
                    append_cnt <= append_cnt - AW'(1);
                end
                if (err_set) begin
                    err <= 1'b1;
                end
                if (shift_ok && (bit_count != '1)) begin
                    bit_count <= bit_count + CNT_W'(1);
                end
            end
        end
    end

    assign append_active = (state == ST_APPEND);
    assign crc_out_bit   = append_active & tx_sr[CRC_W-1];
    assign crc_value     = OUT_INV ? ~crc : crc;
    assign crc_ok        = (crc == RESIDUAL) && (bit_count >= CNT_W'(CRC_W));

endmodule

// File: tb/tb_crc_gen_chk.sv
// Directed bench for crc_gen_chk: zero-init CRC16, USB16 loopback, USB5 token, error/clear/reset cases.
module tb_crc_gen_chk;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    // Instance a: INIT 0, no inversion
    logic        a_clear, a_shift, a_in, a_start, a_adv;
    logic        a_out_bit, a_active, a_done, a_ok, a_err;
    logic [15:0] a_crc_value;
    logic [11:0] a_bit_count;

    // Instances tx / rx: default USB16
    logic        tx_clear, tx_shift, tx_in, tx_start, tx_adv;
    logic        tx_out_bit, tx_active, tx_done, tx_ok, tx_err;
    logic [15:0] tx_crc_value;
    logic [11:0] tx_bit_count;

    logic        rx_clear, rx_shift, rx_in, rx_start, rx_adv;
    logic        rx_out_bit, rx_active, rx_done, rx_ok, rx_err;
    logic [15:0] rx_crc_value;
    logic [11:0] rx_bit_count;

    // Instance t5: USB5
    logic        t5_clear, t5_shift, t5_in, t5_start, t5_adv;
    logic        t5_out_bit, t5_active, t5_done, t5_ok, t5_err;
    logic [4:0]  t5_crc_value;
    logic [11:0] t5_bit_count;

    crc_gen_chk #(.CRC_W(16), .POLY(16'h8005), .INIT(16'h0000), .OUT_INV(1'b0),
                  .RESIDUAL(16'h800D), .CNT_W(12)) u_a (
        .clk(clk), .n_rst(n_rst), .clear(a_clear), .shift_enable(a_shift),
        .serial_in(a_in), .append_start(a_start), .append_advance(a_adv),
        .crc_out_bit(a_out_bit), .append_active(a_active), .append_done(a_done),
        .crc_value(a_crc_value), .crc_ok(a_ok), .bit_count(a_bit_count), .err(a_err));

    crc_gen_chk u_tx (
        .clk(clk), .n_rst(n_rst), .clear(tx_clear), .shift_enable(tx_shift),
        .serial_in(tx_in), .append_start(tx_start), .append_advance(tx_adv),
        .crc_out_bit(tx_out_bit), .append_active(tx_active), .append_done(tx_done),
        .crc_value(tx_crc_value), .crc_ok(tx_ok), .bit_count(tx_bit_count), .err(tx_err));

    crc_gen_chk u_rx (
        .clk(clk), .n_rst(n_rst), .clear(rx_clear), .shift_enable(rx_shift),
        .serial_in(rx_in), .append_start(rx_start), .append_advance(rx_adv),
        .crc_out_bit(rx_out_bit), .append_active(rx_active), .append_done(rx_done),
        .crc_value(rx_crc_value), .crc_ok(rx_ok), .bit_count(rx_bit_count), .err(rx_err));

    crc_gen_chk #(.CRC_W(5), .POLY(USB5_POLY), .INIT(USB5_INIT), .OUT_INV(1'b1),
                  .RESIDUAL(USB5_RESIDUAL), .CNT_W(12)) u_t5 (
        .clk(clk), .n_rst(n_rst), .clear(t5_clear), .shift_enable(t5_shift),
        .serial_in(t5_in), .append_start(t5_start), .append_advance(t5_adv),
        .crc_out_bit(t5_out_bit), .append_active(t5_active), .append_done(t5_done),
        .crc_value(t5_crc_value), .crc_ok(t5_ok), .bit_count(t5_bit_count), .err(t5_err));

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance the given number of clocks with the current inputs, then settle 1 time unit.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Reference CRC16 (USB poly, all-ones init), bit 63 sent first.
    function automatic logic [15:0] usb16Model(input logic [63:0] data);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int i = 63; i >= 0; i--) begin
            fb = data[i] ^ r[15];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] frame;
        logic [15:0] exp_tx;
        logic [10:0] token;
        logic [4:0]  exp5;
        int          done_count;

        {a_clear, a_shift, a_in, a_start, a_adv}      = '0;
        {tx_clear, tx_shift, tx_in, tx_start, tx_adv} = '0;
        {rx_clear, rx_shift, rx_in, rx_start, rx_adv} = '0;
        {t5_clear, t5_shift, t5_in, t5_start, t5_adv} = '0;
        n_rst = 1'b0;
        applyStimulus(2);

        checkOutput("rst_crc_value", tx_crc_value, 16'h0000);
        checkOutput("rst_crc_ok",    tx_ok,        1'b0);
        checkOutput("rst_bit_count", tx_bit_count, 12'd0);
        checkOutput("rst_err",       tx_err,       1'b0);
        checkOutput("rst_active",    tx_active,    1'b0);
        checkOutput("rst_out_bit",   tx_out_bit,   1'b0);
        checkOutput("rst_done",      tx_done,      1'b0);
        checkOutput("rst_a_value",   a_crc_value,  16'h0000);
        n_rst = 1'b1;
        applyStimulus(1);

        // Zero-init CRC16: bits 1,0
        a_shift = 1'b1;
        a_in    = 1'b1;
        applyStimulus(1);
        checkOutput("a_after_1", a_crc_value, 16'h8005);
        a_in = 1'b0;
        applyStimulus(1);
        a_shift = 1'b0;
        checkOutput("a_after_10", a_crc_value, 16'h800F);
        checkOutput("a_bit_count", a_bit_count, 12'd2);
        checkOutput("a_crc_ok", a_ok, 1'b0);
        checkOutput("a_err", a_err, 1'b0);
        checkOutput("a_active", a_active, 1'b0);
        checkOutput("a_out_bit", a_out_bit, 1'b0);
        checkOutput("a_done", a_done, 1'b0);

        // USB16 frame into tx and rx together
        frame  = {$urandom(), $urandom()};
        exp_tx = ~usb16Model(frame);
        tx_shift = 1'b1;
        rx_shift = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tx_in = frame[63-i];
            rx_in = frame[63-i];
            applyStimulus(1);
        end
        tx_shift = 1'b0;
        rx_shift = 1'b0;
        checkOutput("tx_frame_crc", tx_crc_value, exp_tx);
        checkOutput("tx_frame_count", tx_bit_count, 12'd64);
        checkOutput("rx_frame_crc", rx_crc_value, exp_tx);

        tx_start = 1'b1;
        applyStimulus(1);
        tx_start = 1'b0;
        checkOutput("tx_active_start", tx_active, 1'b1);

        done_count = 0;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("tx_bit%0d", i), tx_out_bit, exp_tx[15-i]);
            rx_in    = tx_out_bit;
            rx_shift = 1'b1;
            tx_adv   = 1'b1;
            applyStimulus(1);
            if (tx_done) done_count++;
        end
        tx_adv   = 1'b0;
        rx_shift = 1'b0;
        checkOutput("tx_done_pulse", tx_done, 1'b1);
        checkOutput("tx_active_end", tx_active, 1'b0);
        checkOutput("tx_done_count", done_count, 1);
        checkOutput("tx_crc_kept", tx_crc_value, exp_tx);
        checkOutput("rx_residual", rx_crc_value, 16'h7FF2);
        checkOutput("rx_crc_ok", rx_ok, 1'b1);
        checkOutput("rx_bit_count", rx_bit_count, 12'd80);
        checkOutput("rx_err", rx_err, 1'b0);
        checkOutput("rx_active", rx_active, 1'b0);
        checkOutput("rx_out_bit", rx_out_bit, 1'b0);
        checkOutput("rx_done", rx_done, 1'b0);

        // Back-to-back append in the done cycle, then clear after 7 advances
        tx_start = 1'b1;
        applyStimulus(1);
        tx_start = 1'b0;
        checkOutput("b2b_active", tx_active, 1'b1);
        checkOutput("b2b_done_low", tx_done, 1'b0);
        checkOutput("b2b_first_bit", tx_out_bit, exp_tx[15]);
        tx_adv = 1'b1;
        applyStimulus(7);
        tx_adv = 1'b0;
        checkOutput("mid_active", tx_active, 1'b1);
        tx_clear = 1'b1;
        applyStimulus(1);
        tx_clear = 1'b0;
        checkOutput("clr_active", tx_active, 1'b0);
        checkOutput("clr_done", tx_done, 1'b0);
        checkOutput("clr_crc_value", tx_crc_value, 16'h0000);
        checkOutput("clr_bit_count", tx_bit_count, 12'd0);
        applyStimulus(1);
        checkOutput("clr_done_later", tx_done, 1'b0);

        // append_start with shift_enable in the same cycle
        tx_shift = 1'b1;
        tx_in    = 1'b1;
        tx_start = 1'b1;
        applyStimulus(1);
        tx_shift = 1'b0;
        tx_start = 1'b0;
        checkOutput("coll_err", tx_err, 1'b1);
        checkOutput("coll_count", tx_bit_count, 12'd0);
        checkOutput("coll_active", tx_active, 1'b1);
        checkOutput("coll_crc", tx_crc_value, 16'h0000);
        tx_clear = 1'b1;
        applyStimulus(1);
        tx_clear = 1'b0;
        checkOutput("coll_clr_err", tx_err, 1'b0);
        checkOutput("coll_clr_active", tx_active, 1'b0);

        // shift_enable during APPEND
        tx_start = 1'b1;
        applyStimulus(1);
        tx_start = 1'b0;
        tx_shift = 1'b1;
        applyStimulus(1);
        tx_shift = 1'b0;
        checkOutput("app_shift_err", tx_err, 1'b1);
        checkOutput("app_shift_count", tx_bit_count, 12'd0);
        tx_clear = 1'b1;
        applyStimulus(1);
        tx_clear = 1'b0;

        // append_advance in ACC is harmless
        tx_adv = 1'b1;
        applyStimulus(1);
        tx_adv = 1'b0;
        checkOutput("acc_adv_err", tx_err, 1'b0);
        checkOutput("acc_adv_done", tx_done, 1'b0);
        checkOutput("acc_adv_active", tx_active, 1'b0);

        // USB5 token: addr 0x15, endp 0xE, LSB first
        token = {4'hE, 7'h15};
        exp5  = 5'b10111;
        t5_shift = 1'b1;
        for (int i = 0; i < 11; i++) begin
            t5_in = token[i];
            applyStimulus(1);
        end
        t5_shift = 1'b0;
        checkOutput("t5_crc_value", t5_crc_value, exp5);
        checkOutput("t5_bit_count", t5_bit_count, 12'd11);
        checkOutput("t5_crc_ok", t5_ok, 1'b0);
        t5_start = 1'b1;
        applyStimulus(1);
        t5_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t5_bit%0d", i), t5_out_bit, exp5[4-i]);
            checkOutput($sformatf("t5_active%0d", i), t5_active, 1'b1);
            t5_adv = 1'b1;
            applyStimulus(1);
        end
        t5_adv = 1'b0;
        checkOutput("t5_done", t5_done, 1'b1);
        checkOutput("t5_err", t5_err, 1'b0);

        // Asynchronous reset in the middle of an append
        tx_in    = 1'b1;
        tx_shift = 1'b1;
        applyStimulus(1);
        tx_shift = 1'b0;
        tx_start = 1'b1;
        applyStimulus(1);
        tx_start = 1'b0;
        tx_adv   = 1'b1;
        applyStimulus(3);
        checkOutput("pre_rst_active", tx_active, 1'b1);
        checkOutput("pre_rst_count", tx_bit_count, 12'd1);
        n_rst = 1'b0;
        #1;
        checkOutput("arst_active", tx_active, 1'b0);
        checkOutput("arst_out_bit", tx_out_bit, 1'b0);
        checkOutput("arst_done", tx_done, 1'b0);
        checkOutput("arst_crc_value", tx_crc_value, 16'h0000);
        checkOutput("arst_bit_count", tx_bit_count, 12'd0);
        checkOutput("arst_err", tx_err, 1'b0);
        checkOutput("arst_crc_ok", tx_ok, 1'b0);
        checkOutput("arst_rx_value", rx_crc_value, 16'h0000);
        checkOutput("arst_t5_value", t5_crc_value, 5'h00);
        tx_adv = 1'b0;
        applyStimulus(1);
        n_rst = 1'b1;
        applyStimulus(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
